// File: rtl/run_control_pkg.sv
// Shared state encoding for the multi-channel run-state controller.
package run_control_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET = 3'd0,
        ST_IDLE  = 3'd1,
        ST_VETO  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // States in which the frame-aligned write enables are allowed to be non-zero.
    function automatic logic is_open(input state_t s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/run_control_mc_full_hysteresis.sv
// Per-channel prog-full hysteresis: the stall flag only follows prog_full after
// FULL_HOLD consecutive cycles of disagreement, so short full glitches are ignored.
module full_hysteresis #(
    parameter int FULL_HOLD = 50,
    parameter int FULL_W    = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_prog_full,
    output logic o_stall,
    output logic o_rise
);

    localparam logic [FULL_W-1:0] HOLD_TC = FULL_W'(FULL_HOLD - 1);

    logic [FULL_W-1:0] r_cnt;
    logic              r_stall;
    logic              w_diff;
    logic              w_toggle;

    assign w_diff   = i_prog_full ^ r_stall;
    assign w_toggle = w_diff && (r_cnt >= HOLD_TC);

    // Count consecutive disagreement cycles; flip the stall flag on the last one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else if (w_toggle) begin
            r_cnt   <= '0;
            r_stall <= ~r_stall;
        end else if (w_diff) begin
            r_cnt   <= r_cnt + FULL_W'(1);
        end else begin
            r_cnt   <= '0;
        end
    end

    assign o_stall = r_stall;
    // Strobes in the cycle whose edge sets the stall flag.
    assign o_rise  = w_toggle & ~r_stall;

endmodule

// File: rtl/run_control_mc.sv
// Multi-channel run-state controller: command decode, post-start write veto,
// drain handling and frame-aligned per-channel FIFO write enables.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RESET | after hard reset, waiting for the first command
// ST_IDLE  | stopped; write enables held low
// ST_VETO  | post-START settling window, writes vetoed
// ST_RUN   | running; channels open/close on their FRAME_END
// ST_DRAIN | stop requested; each channel closes at its next FRAME_END
module run_control_mc
    import run_control_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int VETO_CYCLES   = 4000,
    parameter int VETO_W        = 16,
    parameter int FULL_HOLD     = 50,
    parameter int FULL_W        = 10,
    parameter int DRAIN_TIMEOUT = 65535,
    parameter int DRAIN_W       = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START_PULSE,
    input  logic                STOP_PULSE,
    input  logic                INIT_PULSE,
    input  logic                SOFT_RST_PULSE,
    input  logic [N_CH-1:0]     CH_MASK,
    input  logic [N_CH-1:0]     FRAME_END,
    input  logic [N_CH-1:0]     FIFO_PROG_FULL,
    output logic [STATE_W-1:0]  STATE,
    output logic [N_CH-1:0]     FIFO_WR_EN,
    output logic                RST_SIG_PULSE,
    output logic                VETO_ACTIVE,
    output logic [N_CH-1:0]     FULL_STALL,
    output logic [N_CH-1:0]     OVERFLOW_STICKY
);

    localparam logic [VETO_W-1:0]  VETO_TC  = VETO_W'(VETO_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_TC = DRAIN_W'(DRAIN_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VETO_W-1:0]  r_veto_cnt;
    logic [VETO_W-1:0]  w_veto_cnt_nxt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [DRAIN_W-1:0] w_drain_cnt_nxt;
    logic [N_CH-1:0]    r_wr_en;
    logic [N_CH-1:0]    w_wr_en_nxt;
    logic [N_CH-1:0]    r_sticky;
    logic [N_CH-1:0]    w_sticky_nxt;
    logic               w_sticky_clr;
    logic               r_rst_pulse;
    logic               w_rst_pulse_nxt;
    logic [N_CH-1:0]    w_stall;
    logic [N_CH-1:0]    w_rise;
    logic [N_CH-1:0]    w_want;

    for (genvar g = 0; g < N_CH; g++) begin : g_hyst
        full_hysteresis #(
            .FULL_HOLD (FULL_HOLD),
            .FULL_W    (FULL_W)
        ) u_hyst (
            .i_clk       (CLK),
            .i_rst       (RST),
            .i_prog_full (FIFO_PROG_FULL[g]),
            .o_stall     (w_stall[g]),
            .o_rise      (w_rise[g])
        );
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_RESET;
            r_veto_cnt  <= '0;
            r_drain_cnt <= '0;
            r_wr_en     <= '0;
            r_sticky    <= '0;
            r_rst_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_veto_cnt  <= w_veto_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_sticky    <= w_sticky_nxt;
            r_rst_pulse <= w_rst_pulse_nxt;
        end
    end

    // Prioritised command decode, timed exits and per-channel enable/sticky update.
    always_comb begin
        w_state_nxt     = r_state;
        w_veto_cnt_nxt  = r_veto_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_rst_pulse_nxt = 1'b0;
        w_sticky_clr    = 1'b0;

        if (START_PULSE) begin
            w_state_nxt     = ST_VETO;
            w_veto_cnt_nxt  = '0;
            w_rst_pulse_nxt = 1'b1;
            w_sticky_clr    = 1'b1;
        end else if (STOP_PULSE) begin
            w_state_nxt     = (r_state == ST_RUN) ? ST_DRAIN : ST_IDLE;
            w_drain_cnt_nxt = '0;
            w_rst_pulse_nxt = 1'b1;
        end else if (INIT_PULSE) begin
            w_state_nxt     = ST_IDLE;
            w_sticky_clr    = 1'b1;
        end else if (SOFT_RST_PULSE) begin
            w_state_nxt     = ST_IDLE;
            w_rst_pulse_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_VETO: begin
                    if (r_veto_cnt >= VETO_TC) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_veto_cnt_nxt = r_veto_cnt + VETO_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if ((r_wr_en == '0) || (r_drain_cnt >= DRAIN_TC)) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_drain_cnt != '1) begin
                        w_drain_cnt_nxt = r_drain_cnt + DRAIN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        // Frame-end update sees the pre-transition state; leaving RUN/DRAIN clears at once.
        w_want      = (r_state == ST_RUN) ? (CH_MASK & ~w_stall) : '0;
        w_wr_en_nxt = is_open(w_state_nxt) ? ((FRAME_END & w_want) | (~FRAME_END & r_wr_en)) : '0;

        w_sticky_nxt = w_sticky_clr ? '0 : (r_sticky | (w_rise & r_wr_en));
    end

    assign STATE           = r_state;
    assign FIFO_WR_EN      = r_wr_en;
    assign RST_SIG_PULSE   = r_rst_pulse;
    assign VETO_ACTIVE     = (r_state == ST_VETO);
    assign FULL_STALL      = w_stall;
    assign OVERFLOW_STICKY = r_sticky;

endmodule

// File: tb/tb_run_control_mc.sv
// Bench for run_control_mc: behavioural model plus directed literal checks and
// a randomized command/frame/prog-full phase.
module tb_run_control_mc;

    localparam int N_CH          = 4;
    localparam int VETO_CYCLES   = 8;
    localparam int VETO_W        = 16;
    localparam int FULL_HOLD     = 4;
    localparam int FULL_W        = 10;
    localparam int DRAIN_TIMEOUT = 64;
    localparam int DRAIN_W       = 16;

    localparam int F_STATE  = 0;
    localparam int F_WR     = 1;
    localparam int F_PULSE  = 2;
    localparam int F_VETO   = 3;
    localparam int F_STALL  = 4;
    localparam int F_STICKY = 5;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            START_PULSE = 1'b0;
    logic            STOP_PULSE = 1'b0;
    logic            INIT_PULSE = 1'b0;
    logic            SOFT_RST_PULSE = 1'b0;
    logic [N_CH-1:0] CH_MASK = '0;
    logic [N_CH-1:0] FRAME_END = '0;
    logic [N_CH-1:0] FIFO_PROG_FULL = '0;
    logic [2:0]      STATE;
    logic [N_CH-1:0] FIFO_WR_EN;
    logic            RST_SIG_PULSE;
    logic            VETO_ACTIVE;
    logic [N_CH-1:0] FULL_STALL;
    logic [N_CH-1:0] OVERFLOW_STICKY;

    run_control_mc #(
        .N_CH          (N_CH),
        .VETO_CYCLES   (VETO_CYCLES),
        .VETO_W        (VETO_W),
        .FULL_HOLD     (FULL_HOLD),
        .FULL_W        (FULL_W),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .DRAIN_W       (DRAIN_W)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .START_PULSE     (START_PULSE),
        .STOP_PULSE      (STOP_PULSE),
        .INIT_PULSE      (INIT_PULSE),
        .SOFT_RST_PULSE  (SOFT_RST_PULSE),
        .CH_MASK         (CH_MASK),
        .FRAME_END       (FRAME_END),
        .FIFO_PROG_FULL  (FIFO_PROG_FULL),
        .STATE           (STATE),
        .FIFO_WR_EN      (FIFO_WR_EN),
        .RST_SIG_PULSE   (RST_SIG_PULSE),
        .VETO_ACTIVE     (VETO_ACTIVE),
        .FULL_STALL      (FULL_STALL),
        .OVERFLOW_STICKY (OVERFLOW_STICKY)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    // State as a plain number, time-in-state as an age, prog-full as a streak length.
    int            m_state;
    int            m_age;
    bit [N_CH-1:0] m_wr;
    bit [N_CH-1:0] m_stall;
    bit [N_CH-1:0] m_sticky;
    bit            m_pulse;
    int            m_streak [N_CH];

    always @(posedge CLK or posedge RST) begin : model
        int            cmd;
        int            nxt;
        bit [N_CH-1:0] want;
        bit [N_CH-1:0] rise;
        if (RST) begin
            m_state  = 0;
            m_age    = 0;
            m_wr     = '0;
            m_stall  = '0;
            m_sticky = '0;
            m_pulse  = 1'b0;
            for (int i = 0; i < N_CH; i++) m_streak[i] = 0;
        end else begin
            cmd  = START_PULSE ? 1 : STOP_PULSE ? 2 : INIT_PULSE ? 3 : SOFT_RST_PULSE ? 4 : 0;
            want = (m_state == 3) ? (CH_MASK & ~m_stall) : '0;
            rise = '0;
            for (int i = 0; i < N_CH; i++) begin
                if (FIFO_PROG_FULL[i] != m_stall[i]) m_streak[i]++;
                else m_streak[i] = 0;
                if (m_streak[i] == FULL_HOLD) begin
                    rise[i]     = !m_stall[i];
                    m_stall[i]  = !m_stall[i];
                    m_streak[i] = 0;
                end
            end
            m_age++;
            nxt = m_state;
            case (cmd)
                1: nxt = 2;
                2: nxt = (m_state == 3) ? 4 : 1;
                3, 4: nxt = 1;
                default: begin
                    if (m_state == 2 && m_age == VETO_CYCLES) nxt = 3;
                    else if (m_state == 4 && (m_wr == '0 || m_age == DRAIN_TIMEOUT)) nxt = 1;
                end
            endcase
            if (cmd != 0 || nxt != m_state) m_age = 0;
            if (cmd == 1 || cmd == 3) m_sticky = '0;
            else m_sticky = m_sticky | (rise & m_wr);
            m_wr    = (nxt == 3 || nxt == 4) ? ((FRAME_END & want) | (~FRAME_END & m_wr)) : '0;
            m_pulse = (cmd == 1 || cmd == 2 || cmd == 4);
            m_state = nxt;
        end
    end

    // ---------------- compare process ----------------
    int    checks = 0;
    int    errors = 0;
    int    lit_seq = 0;
    int    lit_done = 0;
    int    lit_field [128];
    int    lit_exp   [128];
    string lit_name  [128];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t dut=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic int dut_field(input int f);
        case (f)
            F_STATE:  return int'(STATE);
            F_WR:     return int'(FIFO_WR_EN);
            F_PULSE:  return int'(RST_SIG_PULSE);
            F_VETO:   return int'(VETO_ACTIVE);
            F_STALL:  return int'(FULL_STALL);
            default:  return int'(OVERFLOW_STICKY);
        endcase
    endfunction

    // Outputs sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("state",           int'(STATE),           m_state);
            chk("fifo_wr_en",      int'(FIFO_WR_EN),      int'(m_wr));
            chk("rst_sig_pulse",   int'(RST_SIG_PULSE),   int'(m_pulse));
            chk("veto_active",     int'(VETO_ACTIVE),     int'(m_state == 2));
            chk("full_stall",      int'(FULL_STALL),      int'(m_stall));
            chk("overflow_sticky", int'(OVERFLOW_STICKY), int'(m_sticky));
        end
        while (lit_done < lit_seq) begin
            chk(lit_name[lit_done], dut_field(lit_field[lit_done]), lit_exp[lit_done]);
            lit_done++;
        end
    end

    // ---------------- stimulus ----------------
    // Queue a literal expectation, checked at the next falling edge.
    task automatic expect_lit(input int f, input int v, input string nm);
        lit_field[lit_seq] = f;
        lit_exp[lit_seq]   = v;
        lit_name[lit_seq]  = nm;
        lit_seq++;
    endtask

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
            #1;
        end
    endtask

    int drain_exp [4] = '{14, 12, 8, 0};
    int fe_div;

    initial begin
        expect_lit(F_STATE,  0, "reset_state");
        expect_lit(F_WR,     0, "reset_wr_en");
        expect_lit(F_PULSE,  0, "reset_pulse");
        expect_lit(F_STICKY, 0, "reset_sticky");
        repeat (2) @(negedge CLK);
        #1;
        RST = 1'b0;

        // START at cycle 0: VETO for cycles 1..8, RUN at 9
        START_PULSE = 1'b1;
        expect_lit(F_STATE, 2, "start_state_c1");
        expect_lit(F_PULSE, 1, "start_pulse_c1");
        expect_lit(F_VETO,  1, "start_veto_c1");
        clk_n(1);
        START_PULSE = 1'b0;
        expect_lit(F_PULSE, 0, "pulse_c2");
        clk_n(1);
        clk_n(5);
        expect_lit(F_STATE, 2, "veto_c8");
        clk_n(1);
        CH_MASK   = 4'b1111;
        FRAME_END = 4'b1111;
        expect_lit(F_STATE, 3, "run_c9");
        expect_lit(F_WR,    0, "wr_zero_c9");
        clk_n(1);
        FRAME_END = '0;
        clk_n(2);

        // Masked frame-aligned open, hold without FRAME_END
        CH_MASK   = 4'b0101;
        FRAME_END = 4'b1111;
        expect_lit(F_WR, 4'b0101, "mask_0101");
        clk_n(1);
        FRAME_END = '0;
        CH_MASK   = 4'b1111;
        expect_lit(F_WR, 4'b0101, "hold_no_fe");
        clk_n(3);
        FRAME_END = 4'b1111;
        expect_lit(F_WR, 4'b1111, "all_open");
        clk_n(1);
        FRAME_END = '0;

        // Hysteresis on channel 2
        FIFO_PROG_FULL[2] = 1'b1;
        clk_n(3);
        FIFO_PROG_FULL[2] = 1'b0;
        expect_lit(F_STALL, 0, "pf3_no_stall");
        clk_n(1);
        FIFO_PROG_FULL[2] = 1'b1;
        clk_n(3);
        expect_lit(F_STALL,  4'b0100, "pf4_stall");
        expect_lit(F_STICKY, 4'b0100, "pf4_sticky");
        expect_lit(F_WR,     4'b1111, "stall_wr_held");
        clk_n(1);
        FRAME_END = 4'b0100;
        expect_lit(F_WR, 4'b1011, "stall_close_ch2");
        clk_n(1);
        FRAME_END = '0;
        FIFO_PROG_FULL[2] = 1'b0;
        clk_n(2);
        expect_lit(F_STALL, 4'b0100, "unstall_after3");
        clk_n(1);
        expect_lit(F_STALL,  0,       "unstall_after4");
        expect_lit(F_STICKY, 4'b0100, "sticky_held");
        clk_n(1);

        // STOP with simultaneous FRAME_END, then per-channel drain
        STOP_PULSE = 1'b1;
        FRAME_END  = 4'b1111;
        expect_lit(F_STATE, 4,       "stop_drain");
        expect_lit(F_WR,    4'b1111, "stop_fe_pre_state");
        expect_lit(F_PULSE, 1,       "stop_pulse");
        clk_n(1);
        STOP_PULSE = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            FRAME_END = 4'(1 << i);
            expect_lit(F_WR, drain_exp[i], "drain_close");
            clk_n(1);
        end
        FRAME_END = '0;
        expect_lit(F_STATE, 1, "drain_done_idle");
        clk_n(1);

        // Drain timeout
        START_PULSE = 1'b1;
        clk_n(1);
        START_PULSE = 1'b0;
        clk_n(7);
        FRAME_END = 4'b1111;
        clk_n(2);
        FRAME_END  = '0;
        STOP_PULSE = 1'b1;
        expect_lit(F_STATE, 4, "timeout_drain");
        expect_lit(F_WR,    4'b1111, "timeout_wr_open");
        clk_n(1);
        STOP_PULSE = 1'b0;
        clk_n(62);
        expect_lit(F_STATE, 4, "drain_cycle64");
        clk_n(1);
        expect_lit(F_STATE, 1, "timeout_idle");
        expect_lit(F_WR,    0, "timeout_wr_zero");
        clk_n(1);

        // START beats STOP; INIT in VETO
        START_PULSE = 1'b1;
        STOP_PULSE  = 1'b1;
        expect_lit(F_STATE, 2, "start_beats_stop");
        clk_n(1);
        START_PULSE = 1'b0;
        STOP_PULSE  = 1'b0;
        clk_n(1);
        INIT_PULSE = 1'b1;
        expect_lit(F_STATE, 1, "init_in_veto");
        expect_lit(F_PULSE, 0, "init_no_pulse");
        clk_n(1);
        INIT_PULSE = 1'b0;
        clk_n(1);

        // Randomized phase
        fe_div = 4;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) fe_div = (($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 3 : 15));
            START_PULSE    = ($urandom_range(0, 149) == 0);
            STOP_PULSE     = ($urandom_range(0, 79) == 0);
            INIT_PULSE     = ($urandom_range(0, 299) == 0);
            SOFT_RST_PULSE = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 99) == 0) CH_MASK = 4'($urandom_range(0, 15));
            for (int i = 0; i < N_CH; i++) begin
                FRAME_END[i] = (fe_div != 0) && ($urandom_range(0, fe_div) == 0);
                if ($urandom_range(0, 4) == 0) FIFO_PROG_FULL[i] = ~FIFO_PROG_FULL[i];
            end
            clk_n(1);
        end
        START_PULSE    = 1'b0;
        STOP_PULSE     = 1'b0;
        INIT_PULSE     = 1'b0;
        SOFT_RST_PULSE = 1'b0;
        FIFO_PROG_FULL = '0;
        CH_MASK        = 4'b1111;
        FRAME_END      = '0;
        clk_n(8);

        // Asynchronous reset in the middle of RUN
        START_PULSE = 1'b1;
        clk_n(1);
        START_PULSE = 1'b0;
        clk_n(9);
        FRAME_END = 4'b1111;
        expect_lit(F_WR, 4'b1111, "pre_rst_open");
        clk_n(1);
        FRAME_END = '0;
        @(posedge CLK);
        #2;
        RST = 1'b1;
        expect_lit(F_STATE,  0, "async_rst_state");
        expect_lit(F_WR,     0, "async_rst_wr");
        expect_lit(F_PULSE,  0, "async_rst_pulse");
        expect_lit(F_VETO,   0, "async_rst_veto");
        expect_lit(F_STALL,  0, "async_rst_stall");
        expect_lit(F_STICKY, 0, "async_rst_sticky");
        @(negedge CLK);
        #1;
        clk_n(2);
        RST = 1'b0;
        clk_n(3);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_control_mc.md
Name: run_control_mc

Overview:
Multi-channel successor to the single-channel run-state controller. It decodes START/STOP/INIT/soft-reset command pulses into a run state machine with a programmable post-start write veto. It also produces one frame-aligned FIFO write enable per readout channel, gated by a per-channel mask and by hysteretic prog-full backpressure. It sits between the command register block and the per-channel event FIFOs.

Parameters:
N_CH, 4, number of readout channels / FIFOs
VETO_CYCLES, 4000, write-veto length after START, in CLK cycles
VETO_W, 16, veto counter width (2**VETO_W > VETO_CYCLES)
FULL_HOLD, 50, consecutive cycles of prog-full change required to toggle a channel's stall state
FULL_W, 10, hysteresis counter width (2**FULL_W > FULL_HOLD)
DRAIN_TIMEOUT, 65535, maximum DRAIN duration in cycles before forced IDLE
DRAIN_W, 16, drain counter width

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
START_PULSE  in  1  one-cycle start command
STOP_PULSE  in  1  one-cycle stop command
INIT_PULSE  in  1  one-cycle init command
SOFT_RST_PULSE  in  1  one-cycle soft-reset command
CH_MASK  in  N_CH  1 = channel participates in run; sampled continuously
FRAME_END  in  N_CH  per-channel end-of-frame strobe
FIFO_PROG_FULL  in  N_CH  per-channel FIFO programmable-full
STATE  out  3  0 RESET_ST, 1 IDLE, 2 VETO, 3 RUN, 4 DRAIN
FIFO_WR_EN  out  N_CH  per-channel frame-aligned write enable
RST_SIG_PULSE  out  1  one-cycle front-end reset pulse
VETO_ACTIVE  out  1  high while STATE==VETO
FULL_STALL  out  N_CH  current per-channel stall state
OVERFLOW_STICKY  out  N_CH  sticky: stall asserted while channel was still writing

Behaviour:
- RST (async): STATE=RESET_ST; all counters 0; every output 0.
- Command priority in one cycle: START > STOP > INIT > SOFT_RST; lower-priority pulses in the same cycle are ignored.
- START, any state -> VETO: veto counter = 0; OVERFLOW_STICKY cleared.
- VETO: counter increments each cycle; the cycle the counter equals VETO_CYCLES-1 -> RUN. VETO therefore lasts exactly VETO_CYCLES cycles.
- STOP: from RUN -> DRAIN; from VETO -> IDLE; from RESET_ST/IDLE/DRAIN -> IDLE.
- INIT or SOFT_RST, any state -> IDLE. FIFO_WR_EN goes to 0 on the next edge, not frame-aligned. INIT also clears OVERFLOW_STICKY.
- DRAIN: drain counter increments each cycle. Exit to IDLE on the first cycle where FIFO_WR_EN==0, or when the counter reaches DRAIN_TIMEOUT-1 (forced exit).
- RST_SIG_PULSE: registered; high exactly one cycle, one cycle after any accepted START, STOP or SOFT_RST.
- Stall hysteresis, per channel: the counter increments while FIFO_PROG_FULL[i] != FULL_STALL[i], and is cleared otherwise. When the count reaches FULL_HOLD-1, toggle FULL_STALL[i] and clear the counter. Active in every state.
- want[i] = (STATE==RUN) & CH_MASK[i] & ~FULL_STALL[i].
- FIFO_WR_EN[i] by state:
  - RUN or DRAIN: loads want[i] only on a cycle with FRAME_END[i]=1, otherwise holds. Result is visible the cycle after FRAME_END.
  - RESET_ST/IDLE/VETO: forced 0.
- OVERFLOW_STICKY[i] is set when FULL_STALL[i] toggles 0->1 while FIFO_WR_EN[i]==1.
- Simultaneous FRAME_END and STOP: the frame-end update uses the pre-transition state, so want=1 if running. The channel closes at its next FRAME_END.
- All counters saturate and never wrap.

Decomposition:
- Package run_control_pkg: state encoding localparams (ST_RESET, ST_IDLE, ST_VETO, ST_RUN, ST_DRAIN) and the 3-bit state width.
- Sub-module full_hysteresis (one instance per channel via generate): input prog_full; outputs stall, rise strobe; parameters FULL_HOLD and FULL_W.

Test Plan:
(bench parameters: N_CH=4, VETO_CYCLES=8, FULL_HOLD=4, DRAIN_TIMEOUT=64)
- RST, then START at cycle 0 -> STATE=2 cycles 1-8, STATE=3 at cycle 9; RST_SIG_PULSE high only at cycle 1; FIFO_WR_EN stays 0 until the first FRAME_END after cycle 9.
- RUN, CH_MASK=4'b0101, FRAME_END=4'b1111 at t -> FIFO_WR_EN=4'b0101 at t+1; no change without FRAME_END.
- RUN, FIFO_PROG_FULL[2] high for 3 cycles -> no stall. High for 4 cycles -> FULL_STALL[2]=1, OVERFLOW_STICKY[2]=1, FIFO_WR_EN[2] drops the cycle after the next FRAME_END[2]. Low for 4 cycles -> stall clears.
- RUN with all enables 1, STOP -> STATE=4; each channel drops after its own FRAME_END; STATE=1 once all are 0. With FRAME_END held 0 -> STATE=1 after 64 cycles, FIFO_WR_EN forced 0.
- START and STOP in the same cycle -> START wins (STATE=2). INIT during VETO -> STATE=1 next cycle, no RST_SIG_PULSE.
- RST asserted mid-RUN, asynchronously -> all outputs 0 immediately, STATE=0.
